stroke_painter: RTL
===================

Name: stroke_painter

Overview:
- Consumer end of the stroke-point stream produced by the stroke generator.
- Accepts a stroke header (brush radius, colour) followed by control points over a valid/ready handshake.
- For each point, rasterises a filled circular brush and issues per-pixel write requests to the canvas memory port.
- Sits between the stroke generator and the canvas frame-buffer arbiter.

Parameters:
IMG_W, 640, canvas width in pixels
IMG_H, 480, canvas height in pixels
ADDR_W, 19, canvas word-address width
MAX_R, 8, largest brush radius; larger requests are clamped

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle pulse; begins a stroke, latches i_R and i_color
i_R  in  4  brush radius, 0 means single pixel
i_color  in  24  stroke colour RGB888
i_pt_valid  in  1  control point valid
i_x  in  10  point x coordinate
i_y  in  10  point y coordinate
i_last  in  1  marks the final point of the stroke, qualified by i_pt_valid
o_pt_ready  out  1  painter can accept a point
o_wr_req  out  1  canvas write request
o_wr_addr  out  ADDR_W  write address, y*IMG_W+x
o_wr_data  out  24  write data, the latched colour
i_wr_gnt  in  1  write accepted this cycle
o_busy  out  1  stroke in progress
o_done  out  1  one-cycle pulse when the stroke completes

Behaviour:
- Clock and reset: single clock i_clk; i_rst_n is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE.
- All outputs are registered.

FSM states: IDLE, WAIT_PT, SCAN, DONE.
- IDLE:
  - On i_start: latch colour and R_eff = min(i_R, MAX_R); go to WAIT_PT.
  - i_start in any other state is ignored.
- WAIT_PT:
  - o_pt_ready=1, o_busy=1.
  - On i_pt_valid & o_pt_ready: latch x, y and last; set dx=dy=-R_eff; go to SCAN.
- SCAN:
  - o_pt_ready=0.
  - Visit offsets in raster order, dx fastest, from -R_eff to +R_eff; dy goes -R_eff to +R_eff.
  - Pixel is painted iff dx²+dy² <= R_eff², 0 <= x+dx < IMG_W and 0 <= y+dy < IMG_H.
  - Offset arithmetic is signed 11-bit; the squared compare is 8-bit unsigned.
  - Painted pixel: assert o_wr_req with o_wr_addr and o_wr_data. Hold all three stable until i_wr_gnt. Advance on the gnt cycle.
  - Unpainted offset: skipped in exactly one cycle, no request.
  - gnt with gnt-to-next-request spacing: a new request may assert the cycle after gnt (back-to-back allowed).
  - After offset (R_eff, R_eff) is consumed: go to DONE if last, else WAIT_PT.
- DONE:
  - o_done=1 for one cycle, o_busy=0.
  - Next state is IDLE.

Boundary rules:
- R=0: one offset visited.
- A fully clipped point produces zero writes but still takes (2R+1)² cycles.
- i_wr_gnt without o_wr_req is ignored.
- Reset mid-stroke: request dropped immediately, return to IDLE, no o_done.

Optional Feature:
STROKE_DEDUP_EN
- Defined: a point equal to the previously accepted point of the same stroke is accepted and dropped without SCAN.
  - Next state is WAIT_PT, or DONE if i_last.
  - The first point of each stroke is always painted.
- Undefined: every accepted point is rasterised.

Test Plan:
- R=0, colour 0xFF0000, point (10,20) with last, gnt=1 → one write, addr 12810, data FF0000; o_done one cycle after DONE entry; o_busy drops.
- R=1, point (5,5), gnt tied 1 → writes in order 2565, 3204, 3205, 3206, 3845; SCAN lasts 9 cycles.
- R=2, point (0,0) → clipped; writes in order 0, 1, 2, 640, 641, 1280; no out-of-range address ever appears.
- R=1, gnt held low 5 cycles on the first request → o_wr_req, o_wr_addr and o_wr_data stable for 5 cycles; o_pt_ready stays 0; sequence resumes correctly.
- Reset asserted mid-SCAN → all outputs 0 asynchronously, no o_done. A subsequent start with R=0, point (1,0) → single write, addr 1.
- Two identical points (3,3) with R=0, second carries last → one write (addr 1923) with STROKE_DEDUP_EN, two writes without it.

Source files
------------

// File: rtl/stroke_painter.sv
// Brush rasteriser: takes a stroke header plus control points and issues one canvas
// write per pixel inside a filled circle. Define STROKE_DEDUP_EN to drop repeated points.
module stroke_painter #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19,
  parameter int MAX_R  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [3:0]        i_R,
  input  logic [23:0]       i_color,
  input  logic              i_pt_valid,
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  input  logic              i_last,
  output logic              o_pt_ready,
  output logic              o_wr_req,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [23:0]       o_wr_data,
  input  logic              i_wr_gnt,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {IDLE, WAIT_PT, SCAN, DONE} state_t;

  localparam logic [3:0]         MAX_R4 = 4'(MAX_R);
  localparam logic signed [10:0] W_S    = 11'(IMG_W);
  localparam logic signed [10:0] H_S    = 11'(IMG_H);

  state_t              state_q, state_d;
  logic                pt_ready_q, pt_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wr_req_q, wr_req_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [23:0]         wr_data_q, wr_data_d;

  logic [3:0]          r_q, r_d;
  logic [23:0]         color_q, color_d;
  logic [9:0]          x_q, x_d, y_q, y_d;
  logic                last_q, last_d;
  logic signed [10:0]  dx_q, dx_d, dy_q, dy_d;
  logic signed [10:0]  r_s;
  logic                load;

`ifdef STROKE_DEDUP_EN
  logic                have_prev_q, have_prev_d;
  logic [9:0]          prev_x_q, prev_x_d, prev_y_q, prev_y_d;
`endif

  function automatic logic in_brush(input logic [9:0] bx, input logic [9:0] by,
                                    input logic signed [10:0] dx, input logic signed [10:0] dy,
                                    input logic [3:0] r);
    logic signed [10:0] px, py;
    logic [3:0]         ax, ay;
    logic [7:0]         d2, r2;
    px = $signed({1'b0, bx}) + dx;
    py = $signed({1'b0, by}) + dy;
    ax = (dx < 0) ? 4'(-dx) : 4'(dx);
    ay = (dy < 0) ? 4'(-dy) : 4'(dy);
    d2 = ({4'b0, ax} * {4'b0, ax}) + ({4'b0, ay} * {4'b0, ay});
    r2 = {4'b0, r} * {4'b0, r};
    return (d2 <= r2) && (px >= 0) && (px < W_S) && (py >= 0) && (py < H_S);
  endfunction

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] bx, input logic [9:0] by,
                                                 input logic signed [10:0] dx,
                                                 input logic signed [10:0] dy);
    logic signed [10:0] px, py;
    px = $signed({1'b0, bx}) + dx;
    py = $signed({1'b0, by}) + dy;
    return ADDR_W'(py[9:0]) * ADDR_W'(IMG_W) + ADDR_W'(px[9:0]);
  endfunction

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    color_d   = color_q;
    x_d       = x_q;
    y_d       = y_q;
    last_d    = last_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    load      = 1'b0;
    r_s       = $signed({7'b0, r_q});
`ifdef STROKE_DEDUP_EN
    have_prev_d = have_prev_q;
    prev_x_d    = prev_x_q;
    prev_y_d    = prev_y_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          r_d     = (i_R > MAX_R4) ? MAX_R4 : i_R;
          color_d = i_color;
          state_d = WAIT_PT;
`ifdef STROKE_DEDUP_EN
          have_prev_d = 1'b0;
`endif
        end
      end
      WAIT_PT: begin
        if (i_pt_valid && pt_ready_q) begin
`ifdef STROKE_DEDUP_EN
          if (have_prev_q && (i_x == prev_x_q) && (i_y == prev_y_q)) begin
            state_d = i_last ? DONE : WAIT_PT;
          end else begin
            have_prev_d = 1'b1;
            prev_x_d    = i_x;
            prev_y_d    = i_y;
            x_d     = i_x;
            y_d     = i_y;
            last_d  = i_last;
            dx_d    = -r_s;
            dy_d    = -r_s;
            load    = 1'b1;
            state_d = SCAN;
          end
`else
          x_d     = i_x;
          y_d     = i_y;
          last_d  = i_last;
          dx_d    = -r_s;
          dy_d    = -r_s;
          load    = 1'b1;
          state_d = SCAN;
`endif
        end
      end
      SCAN: begin
        // A request holds its offset until granted; a skipped offset advances at once.
        if (!wr_req_q || i_wr_gnt) begin
          if ((dx_q == r_s) && (dy_q == r_s)) begin
            state_d   = last_q ? DONE : WAIT_PT;
            wr_req_d  = 1'b0;
            wr_addr_d = '0;
            wr_data_d = '0;
          end else if (dx_q == r_s) begin
            dx_d = -r_s;
            dy_d = dy_q + 11'sd1;
            load = 1'b1;
          end else begin
            dx_d = dx_q + 11'sd1;
            load = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Evaluate the offset being entered so the request is registered alongside it.
    if (load) begin
      wr_req_d  = in_brush(x_d, y_d, dx_d, dy_d, r_q);
      wr_addr_d = wr_req_d ? pix_addr(x_d, y_d, dx_d, dy_d) : '0;
      wr_data_d = wr_req_d ? color_q : '0;
    end

    pt_ready_d = (state_d == WAIT_PT);
    busy_d     = (state_d == WAIT_PT) || (state_d == SCAN);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      pt_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_req_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      pt_ready_q <= pt_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_req_q   <= wr_req_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge i_clk) begin
    r_q     <= r_d;
    color_q <= color_d;
    x_q     <= x_d;
    y_q     <= y_d;
    last_q  <= last_d;
    dx_q    <= dx_d;
    dy_q    <= dy_d;
  end

`ifdef STROKE_DEDUP_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) have_prev_q <= 1'b0;
    else          have_prev_q <= have_prev_d;
  end

  always_ff @(posedge i_clk) begin
    prev_x_q <= prev_x_d;
    prev_y_q <= prev_y_d;
  end
`endif

  assign o_pt_ready = pt_ready_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_wr_req   = wr_req_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;

endmodule
